// File: rtl/rv32i_types.sv
// Shared types for the fetch-stage branch target buffer.
//   btb_entry_t   one BTB way: valid, tag, target, 2-bit direction counter
//   CTR_*         2-bit saturating counter encodings
//   ctr_train()   saturating counter step for a resolved direction
package rv32i_types;

   // The tag field is sized for the widest tag (S_INDEX >= 0). The top stores
   // the real tag zero-extended, so the constant upper bits synthesize away.
   localparam int BTB_TAG_MAX = 30;
   // PLRU storage per set: 3-bit tree for 4 ways, fewer bits used below that.
   localparam int BTB_PLRU_W  = 3;

   localparam logic [1:0] CTR_SNT = 2'b00;
   localparam logic [1:0] CTR_WNT = 2'b01;
   localparam logic [1:0] CTR_WT  = 2'b10;
   localparam logic [1:0] CTR_ST  = 2'b11;

   typedef struct packed {
      logic                   valid;
      logic [BTB_TAG_MAX-1:0] tag;
      logic [31:0]            target;
      logic [1:0]             ctr;
   } btb_entry_t;

   function automatic logic [1:0] ctr_train(input logic [1:0] ctr, input logic taken);
      if (taken) begin
         return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
      end
      return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
   endfunction

endpackage

// File: rtl/btb_plru.sv
// Pseudo-LRU victim selection and update for one BTB set. Combinational.
//   plru_bits  in   current PLRU state of the set
//   touched    in   way being hit or filled by this update
//   valid_vec  in   valid bit of every way in the set
//   victim     out  lowest invalid way, else the way the PLRU state points at
//   plru_next  out  PLRU state after marking `touched` most-recently-used
module btb_plru
   import rv32i_types::*;
#(
   parameter int WAYS  = 2,
   parameter int WAY_W = 1
) (
   input  logic [BTB_PLRU_W-1:0] plru_bits,
   input  logic [WAY_W-1:0]      touched,
   input  logic [WAYS-1:0]       valid_vec,
   output logic [WAY_W-1:0]      victim,
   output logic [BTB_PLRU_W-1:0] plru_next
);

   logic [WAY_W-1:0] tree_victim;

   // Each PLRU bit points at the side holding the next victim; touching a way
   // flips the bits on its path to point away from it.
   generate
      if (WAYS == 4) begin : g_four
         // bit0 chooses the pair, bit1 the way in {0,1}, bit2 the way in {2,3}
         always_comb begin
            tree_victim = plru_bits[0] ? {1'b1, plru_bits[2]} : {1'b0, plru_bits[1]};
            plru_next    = plru_bits;
            plru_next[0] = ~touched[1];
            if (touched[1]) begin
               plru_next[2] = ~touched[0];
            end else begin
               plru_next[1] = ~touched[0];
            end
         end
      end else if (WAYS == 2) begin : g_two
         always_comb begin
            tree_victim  = plru_bits[0];
            plru_next    = plru_bits;
            plru_next[0] = ~touched[0];
         end
      end else begin : g_one
         always_comb begin
            tree_victim = '0;
            plru_next   = plru_bits;
         end
      end
   endgenerate

   // Invalid ways are always filled first, lowest index winning.
   always_comb begin
      victim = tree_victim;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_vec[w]) begin
            victim = w[WAY_W-1:0];
         end
      end
   end

   // Some PLRU bits and the touched way go unused for the smaller configurations.
   logic unused_inputs;
   assign unused_inputs = ^{plru_bits, touched};

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer for the fetch stage.
//   clk, rst        clock; asynchronous active-high reset
//   lookup_pc       fetch PC, sampled every cycle
//   hit             registered: a valid tag matched last cycle's lookup_pc
//   pred_target     registered stored target, zero on miss
//   pred_taken      registered hit AND counter[1]
//   update_valid    a resolved branch is reported this cycle
//   update_pc       PC of the resolved branch
//   update_target   its computed target
//   update_taken    its resolved direction
module btb_assoc
   import rv32i_types::*;
#(
   parameter int S_INDEX = 6,
   parameter int WAYS    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] lookup_pc,
   output logic        hit,
   output logic [31:0] pred_target,
   output logic        pred_taken,
   input  logic        update_valid,
   input  logic [31:0] update_pc,
   input  logic [31:0] update_target,
   input  logic        update_taken
);

   localparam int TAG_W = 30 - S_INDEX;
   localparam int SETS  = 1 << S_INDEX;
   localparam int WAY_W = (WAYS == 4) ? 2 : 1;

   generate
      if (WAYS != 1 && WAYS != 2 && WAYS != 4) begin : g_bad_ways
         $error("btb_assoc: WAYS must be 1, 2 or 4");
      end
   endgenerate

   btb_entry_t             entries_q [SETS][WAYS];
   logic [BTB_PLRU_W-1:0]  plru_q    [SETS];

   btb_entry_t             set_d  [WAYS];   // post-update contents of the updated set
   btb_entry_t             lk_set [WAYS];   // set seen by the lookup (forwarded if same set)
   logic [BTB_PLRU_W-1:0]  plru_d;
   logic                   plru_we;

   logic [S_INDEX-1:0]     upd_idx, lk_idx;
   logic [BTB_TAG_MAX-1:0] upd_tag, lk_tag;
   logic                   upd_hit;
   logic [WAY_W-1:0]       upd_way, victim, touched;
   logic [WAYS-1:0]        valid_vec;

   logic                   hit_d, hit_q;
   logic [31:0]            pred_target_d, pred_target_q;
   logic                   pred_taken_d, pred_taken_q;

   always_comb begin
      upd_idx = update_pc[S_INDEX+1:2];
      lk_idx  = lookup_pc[S_INDEX+1:2];
      upd_tag = '0;
      lk_tag  = '0;
      upd_tag[TAG_W-1:0] = update_pc[31:S_INDEX+2];
      lk_tag[TAG_W-1:0]  = lookup_pc[31:S_INDEX+2];
   end

   // Probe the update set. Allocation only happens on a miss, so at most one way matches.
   always_comb begin
      upd_hit   = 1'b0;
      upd_way   = '0;
      valid_vec = '0;
      for (int w = 0; w < WAYS; w++) begin
         valid_vec[w] = entries_q[upd_idx][w].valid;
         if (entries_q[upd_idx][w].valid && entries_q[upd_idx][w].tag == upd_tag) begin
            upd_hit = 1'b1;
            upd_way = w[WAY_W-1:0];
         end
      end
   end

   assign touched = upd_hit ? upd_way : victim;

   btb_plru #(
      .WAYS  (WAYS),
      .WAY_W (WAY_W)
   ) u_plru (
      .plru_bits (plru_q[upd_idx]),
      .touched   (touched),
      .valid_vec (valid_vec),
      .victim    (victim),
      .plru_next (plru_d)
   );

   // NOTE: every signal gets a default at the top of an always_comb so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         set_d[w] = entries_q[upd_idx][w];
      end
      plru_we = 1'b0;
      if (update_valid) begin
         if (upd_hit) begin
            set_d[upd_way].ctr = ctr_train(set_d[upd_way].ctr, update_taken);
            if (update_taken) begin
               set_d[upd_way].target = update_target;
            end
            plru_we = 1'b1;
         end else if (update_taken) begin
            set_d[victim] = '{valid: 1'b1, tag: upd_tag, target: update_target, ctr: CTR_WT};
            plru_we = 1'b1;
         end
      end
   end

   // Same-set forwarding: set_d equals the stored set when no update is
   // present, so the lookup can take it whenever the indices match.
   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         lk_set[w] = (lk_idx == upd_idx) ? set_d[w] : entries_q[lk_idx][w];
      end
      hit_d         = 1'b0;
      pred_target_d = '0;
      pred_taken_d  = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (lk_set[w].valid && lk_set[w].tag == lk_tag) begin
            hit_d         = 1'b1;
            pred_target_d = lk_set[w].target;
            pred_taken_d  = lk_set[w].ctr[1];
         end
      end
   end

   // NOTE: the entry array is reset like any other flop because reset must
   // clear every valid bit asynchronously; it cannot map onto an SRAM macro.
   // NOTE: sequential state uses non-blocking assignments so all flops sample
   // their pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               entries_q[s][w] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
            end
            plru_q[s] <= '0;
         end
         hit_q         <= 1'b0;
         pred_target_q <= '0;
         pred_taken_q  <= 1'b0;
      end else begin
         hit_q         <= hit_d;
         pred_target_q <= pred_target_d;
         pred_taken_q  <= pred_taken_d;
         if (update_valid) begin
            for (int w = 0; w < WAYS; w++) begin
               entries_q[upd_idx][w] <= set_d[w];
            end
         end
         if (plru_we) begin
            plru_q[upd_idx] <= plru_d;
         end
      end
   end

   assign hit         = hit_q;
   assign pred_target = pred_target_q;
   assign pred_taken  = pred_taken_q;

   // Byte offset of the PC carries no information for a 4-byte ISA.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

endmodule

// File: doc/btb_assoc.md
# btb_assoc

Set-associative branch target buffer with tags, valid bits, 2-bit saturating direction counters and pseudo-LRU replacement. It replaces the direct-mapped, untagged target array in the fetch stage: IF presents the fetch PC every cycle and receives a registered hit/target/direction prediction one cycle later. EX reports resolved branches through the update port, which trains counters and allocates entries.

## Interface
Parameters:
- S_INDEX, 6: set-index bits; the buffer has 2^S_INDEX sets.
- WAYS, 2: associativity. Legal values are 1, 2 or 4; any other value is an elaboration error.
- TAG_W, 30-S_INDEX: derived, not overridable.

Ports:
- clk  in  1: clock.
- rst  in  1: reset, asynchronous, active-high.
- lookup_pc  in  32: fetch PC. Sampled every cycle.
- hit  out  1: a valid tag matched lookup_pc from the previous cycle.
- pred_target  out  32: stored target. Zero when hit=0.
- pred_taken  out  1: hit AND counter[1].
- update_valid  in  1: a resolved control-flow instruction is present this cycle.
- update_pc  in  32: PC of the resolved branch.
- update_target  in  32: computed target.
- update_taken  in  1: the resolved direction.

## Operation
- Address split: index = pc[S_INDEX+1:2]; tag = pc[31:S_INDEX+2]. pc[1:0] is ignored.
- Each entry holds valid, tag[TAG_W], target[32] and ctr[2]. Each set holds a PLRU state:
  - 0 bits when WAYS=1.
  - 1 bit when WAYS=2.
  - 3-bit tree when WAYS=4.
- Lookup: compare all ways of the set in parallel. At most one way can match, because allocation only occurs on a miss.
- Update with a hit in way w:
  - ctr increments, saturating at 11, if update_taken; otherwise it decrements, saturating at 00.
  - target is written only if update_taken.
  - PLRU is marked so that it points away from w.
- Update with a miss and update_taken=1: allocate.
  - Victim is the lowest-numbered invalid way; if every way is valid, the PLRU victim.
  - Write valid=1, tag, target and ctr=10.
  - Mark the victim most-recently-used.
- Update with a miss and update_taken=0: no state change.
- Lookup hits never touch PLRU. Replacement is trained only by updates.
- Reset clears every valid bit, sets all ctr to 01 and all PLRU bits to 0, and drives hit=0, pred_target=0 and pred_taken=0.

## Timing
- Lookup latency is 1 cycle. lookup_pc at edge N produces hit, pred_target and pred_taken after edge N+1. All three outputs are registered.
- An update commits at the rising edge on which update_valid=1.
- Same-cycle forwarding: if update_valid=1 and update_pc index equals lookup_pc index in the same cycle, the registered lookup result reflects the post-update state of that set.
  - Example: an allocation of the looked-up PC yields hit=1, ctr=10 and the new target.
- Different sets in the same cycle: the lookup and update proceed independently.
- Reset asserted mid-operation: all state and outputs clear immediately, without waiting for a clock edge. The first lookup after deassertion returns hit=0.
- No backpressure. The block accepts one lookup and one update every cycle.

## Structure
- Add to rv32i_types:
  - typedef btb_entry_t (valid, tag, target, ctr).
  - Counter constants CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11.
- State storage is a flop array: the async reset requires it. rw_array is not reused.
- One sub-module, btb_plru:
  - Inputs: per-set PLRU bits, touched way and valid vector.
  - Outputs: victim way and next PLRU bits.
  - Purely combinational; instantiated once.
- Top-level contents: tag compare, forwarding mux, counter arithmetic and output registers.

## Test plan
- Cold lookup: after reset, lookup 0x0000_0040 -> hit=0, pred_target=0, pred_taken=0.
- Allocate and hit: update pc=0x0000_0040, target=0x0000_0100, taken=1; next cycle lookup 0x40 -> hit=1, target 0x100, pred_taken=1 (ctr=10). Then two not-taken updates -> pred_taken=0 (ctr=00). A third not-taken update -> ctr stays 00.
- Aliasing, WAYS=2, S_INDEX=6: allocate 0x040, 0x140 and 0x240, all in set 16 and all taken. 0x040 is evicted. Lookups give 0x140 hit, 0x240 hit, 0x040 miss.
- PLRU training: allocate A=0x040 and B=0x140, update A taken, then allocate C=0x240 -> B is evicted and A still hits.
- Forwarding: same cycle, update pc 0x80 taken with target 0x200 and lookup 0x80 -> hit=1, target 0x200 on the next cycle. A not-taken miss update -> no allocation, and a later lookup misses.
- Async reset: assert rst between clock edges while hit=1 -> outputs clear before the next edge, and every prior entry misses after release.
